mcu_bus_ctrl: RTL and testbench
===============================

Name: mcu_bus_ctrl

Overview:
- Memory-bus controller between the CPU core and its two slaves: the peripheral block (GPIO/SPI, region 0xF000–0xFFFF) and the external memory port (0x0000–0xEFFF).
- Accepts one CPU access at a time, decodes the region, and drives the peripheral handshake (addr/valid/write_en, read data returned one cycle later) or a req/ready memory handshake.
- Returns read data with a one-cycle ack pulse; a timeout converts a hung slave into an error response.

Parameters:
- PERIPH_NIBBLE, 4'hF: value of addr[15:12] that selects the peripheral region.
- TIMEOUT, 15: maximum wait cycles in PERIPH_WAIT/MEM_WAIT before an error response; range 1..255.
- ERR_DATA, 8'hFF: read data returned on timeout.

Ports:
- clk_in  in  1  clock; all logic on the rising edge.
- reset_n_in  in  1  asynchronous active-low reset.
- cpu_addr_in  in  16  CPU access address.
- cpu_wdata_in  in  8  CPU write data.
- cpu_req_in  in  1  access request; the CPU holds it and its operands stable until cpu_ack_out.
- cpu_we_in  in  1  1 = write, 0 = read.
- cpu_rdata_out  out  8  read data; valid while cpu_ack_out = 1 and held until the next ack.
- cpu_ack_out  out  1  single-cycle completion pulse.
- cpu_err_out  out  1  set with ack on timeout; cleared on the next ack.
- periph_addr_out  out  3  latched addr[2:0].
- periph_addr_valid_out  out  1  one-cycle access strobe to the peripheral.
- periph_write_en_out  out  1  latched we, qualified by the valid strobe.
- periph_wdata_out  out  8  latched write data.
- periph_rdata_in  in  8  peripheral read data.
- periph_data_valid_in  in  1  peripheral read-data valid.
- mem_addr_out  out  16  latched address.
- mem_wdata_out  out  8  latched write data.
- mem_we_out  out  1  latched we.
- mem_req_out  out  1  memory request; held until mem_ready_in.
- mem_rdata_in  in  8  memory read data.
- mem_ready_in  in  1  memory completion; sampled only in MEM_WAIT.

Behaviour:
- Reset (asynchronous, reset_n_in = 0): state IDLE; all outputs 0, including cpu_rdata_out, cpu_err_out, mem_req_out and periph_addr_valid_out; latches and timeout counter cleared.
- Reset mid-access aborts it: mem_req_out and periph strobes drop immediately, and no ack is ever issued for the aborted access.
- States: IDLE, P_ISSUE, PERIPH_WAIT, MEM_WAIT, RESP.
- IDLE: on cpu_req_in = 1, latch addr, wdata and we.
  - addr[15:12] == PERIPH_NIBBLE → P_ISSUE.
  - Otherwise → MEM_WAIT, with mem_req_out = 1 from the next cycle.
  - periph_data_valid_in and mem_ready_in are ignored in IDLE.
- P_ISSUE: periph_addr_valid_out = 1 for exactly this cycle.
  - Write → RESP (err = 0).
  - Read → PERIPH_WAIT.
- PERIPH_WAIT:
  - periph_data_valid_in = 1: capture periph_rdata_in → RESP.
  - Otherwise increment the counter; on reaching TIMEOUT, rdata = ERR_DATA, err = 1 → RESP.
- MEM_WAIT: mem_req_out = 1.
  - mem_ready_in = 1: if read, capture mem_rdata_in; deassert req → RESP.
  - Timeout as in PERIPH_WAIT, for both reads and writes.
  - Ready arriving in the same cycle the counter hits TIMEOUT counts as success; ready wins.
- RESP: cpu_ack_out = 1 for one cycle; counter cleared → IDLE. cpu_req_in is not sampled in RESP. If it is still high in the following IDLE cycle, that is a new access.
- Latency, cycles from the request cycle to the ack cycle:
  - periph write: 2.
  - periph read: 3 with an immediate-valid peripheral.
  - memory: 2 + (cycles until ready).
- cpu_rdata_out is not updated on writes.
- Outputs are registered or decoded from state; the bus is glitch-free on strobes.
- Timeout counter is 8 bits and never wraps; it saturates at TIMEOUT.

Decomposition:
- Package mcu_bus_pkg:
  - bus_state_t enum (IDLE, P_ISSUE, PERIPH_WAIT, MEM_WAIT, RESP).
  - PERIPH_NIBBLE and ERR_DATA defaults.
  - PERIPH_ADDR_W = 3.
- No sub-module; the timeout counter is inline.

Test Plan:
- Peripheral write: req with addr 0xF001, we = 1, wdata 0xA5 → one-cycle periph_addr_valid_out with addr 1, write_en 1, wdata 0xA5; ack 2 cycles after req; err 0; mem_req_out stays 0.
- Peripheral read: addr 0xF006, with the peripheral model returning 0x01 one cycle after the strobe → ack 3 cycles after req; cpu_rdata_out = 0x01.
- Memory read: addr 0x1234, ready after 4 cycles with rdata 0x5A → mem_req_out high 4 cycles, mem_addr_out 0x1234; ack next cycle; rdata 0x5A.
- Timeout: memory read with ready never asserted, TIMEOUT = 15 → ack after the timeout; rdata 0xFF; err 1. A following successful access clears err.
- Reset mid-access: assert reset_n_in = 0 while in MEM_WAIT → mem_req_out 0 immediately; no ack; after release, a new periph read completes normally.
- Back-to-back: req held high across the ack → a second access starts in the IDLE cycle after RESP. A stray periph_data_valid_in pulse in IDLE does not change cpu_rdata_out.

Source files
------------

// File: rtl/mcu_bus_pkg.sv
// Shared types and defaults for the CPU memory-bus controller.
// Holds the state encoding, region/error defaults and bus widths.
package mcu_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P_ISSUE,
    PERIPH_WAIT,
    MEM_WAIT,
    RESP
  } bus_state_t;

  localparam logic [3:0] PERIPH_NIBBLE_DEF = 4'hF;
  localparam logic [7:0] ERR_DATA_DEF      = 8'hFF;
  localparam int         PERIPH_ADDR_W     = 3;
  localparam int         CNT_W             = 8;

  function automatic logic is_periph(input logic [15:0] addr, input logic [3:0] nibble);
    return addr[15:12] == nibble;
  endfunction

endpackage

// File: rtl/mcu_bus_ctrl.sv
// Single-outstanding CPU bus controller steering accesses to the peripheral block
// or the external memory port, with a saturating timeout that turns a hung slave into an error.
module mcu_bus_ctrl
  import mcu_bus_pkg::*;
#(
  parameter logic [3:0] PERIPH_NIBBLE = PERIPH_NIBBLE_DEF,
  parameter int         TIMEOUT       = 15,
  parameter logic [7:0] ERR_DATA      = ERR_DATA_DEF
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic [15:0]              cpu_addr_in,
  input  logic [7:0]               cpu_wdata_in,
  input  logic                     cpu_req_in,
  input  logic                     cpu_we_in,
  output logic [7:0]               cpu_rdata_out,
  output logic                     cpu_ack_out,
  output logic                     cpu_err_out,
  output logic [PERIPH_ADDR_W-1:0] periph_addr_out,
  output logic                     periph_addr_valid_out,
  output logic                     periph_write_en_out,
  output logic [7:0]               periph_wdata_out,
  input  logic [7:0]               periph_rdata_in,
  input  logic                     periph_data_valid_in,
  output logic [15:0]              mem_addr_out,
  output logic [7:0]               mem_wdata_out,
  output logic                     mem_we_out,
  output logic                     mem_req_out,
  input  logic [7:0]               mem_rdata_in,
  input  logic                     mem_ready_in
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  bus_state_t       state_q, state_d;
  logic [15:0]      addr_q;
  logic [7:0]       wdata_q;
  logic             we_q;
  logic             load_ops;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             ack_q;
  logic             pvalid_q;
  logic             pwe_q;
  logic             mreq_q;

  // Next-state and response-data decode; rdata/err only move when heading into RESP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    load_ops = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req_in) begin
          load_ops = 1'b1;
          cnt_d    = '0;
          state_d  = is_periph(cpu_addr_in, PERIPH_NIBBLE) ? P_ISSUE : MEM_WAIT;
        end
      end

      P_ISSUE: begin
        if (we_q) begin
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          state_d = PERIPH_WAIT;
        end
      end

      PERIPH_WAIT: begin
        if (periph_data_valid_in) begin
          rdata_d = periph_rdata_in;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          cnt_d   = TIMEOUT_CNT;
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Ready is checked before the timeout so a last-cycle completion still succeeds.
      MEM_WAIT: begin
        if (mem_ready_in) begin
          if (!we_q) begin
            rdata_d = mem_rdata_in;
          end
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          cnt_d   = TIMEOUT_CNT;
          rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (load_ops) begin
      addr_q  <= cpu_addr_in;
      wdata_q <= cpu_wdata_in;
      we_q    <= cpu_we_in;
    end
  end

  // Strobes are flopped from the upcoming state so the slaves never see decode glitches.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ack_q    <= 1'b0;
      pvalid_q <= 1'b0;
      pwe_q    <= 1'b0;
      mreq_q   <= 1'b0;
    end else begin
      ack_q    <= (state_d == RESP);
      pvalid_q <= (state_d == P_ISSUE);
      pwe_q    <= (state_d == P_ISSUE) && cpu_we_in;
      mreq_q   <= (state_d == MEM_WAIT);
    end
  end

  assign cpu_rdata_out         = rdata_q;
  assign cpu_ack_out           = ack_q;
  assign cpu_err_out           = err_q;
  assign periph_addr_out       = addr_q[PERIPH_ADDR_W-1:0];
  assign periph_addr_valid_out = pvalid_q;
  assign periph_write_en_out   = pwe_q;
  assign periph_wdata_out      = wdata_q;
  assign mem_addr_out          = addr_q;
  assign mem_wdata_out         = wdata_q;
  assign mem_we_out            = we_q;
  assign mem_req_out           = mreq_q;

endmodule

// File: tb/tb_mcu_bus_ctrl.sv
// Scoreboard bench for mcu_bus_ctrl: stimulus pushes the expected ack (cycle, data, err),
// an independent monitor pops and compares on every ack.
module tb_mcu_bus_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic [15:0] cpu_addr_in = '0;
  logic [7:0]  cpu_wdata_in = '0;
  logic        cpu_req_in = 1'b0;
  logic        cpu_we_in = 1'b0;
  logic [7:0]  cpu_rdata_out;
  logic        cpu_ack_out;
  logic        cpu_err_out;
  logic [2:0]  periph_addr_out;
  logic        periph_addr_valid_out;
  logic        periph_write_en_out;
  logic [7:0]  periph_wdata_out;
  logic [7:0]  periph_rdata_in = '0;
  logic        periph_data_valid_in = 1'b0;
  logic [15:0] mem_addr_out;
  logic [7:0]  mem_wdata_out;
  logic        mem_we_out;
  logic        mem_req_out;
  logic [7:0]  mem_rdata_in = '0;
  logic        mem_ready_in = 1'b0;

  mcu_bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .cpu_addr_in(cpu_addr_in), .cpu_wdata_in(cpu_wdata_in), .cpu_req_in(cpu_req_in),
    .cpu_we_in(cpu_we_in), .cpu_rdata_out(cpu_rdata_out), .cpu_ack_out(cpu_ack_out),
    .cpu_err_out(cpu_err_out), .periph_addr_out(periph_addr_out),
    .periph_addr_valid_out(periph_addr_valid_out), .periph_write_en_out(periph_write_en_out),
    .periph_wdata_out(periph_wdata_out), .periph_rdata_in(periph_rdata_in),
    .periph_data_valid_in(periph_data_valid_in), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_we_out(mem_we_out), .mem_req_out(mem_req_out),
    .mem_rdata_in(mem_rdata_in), .mem_ready_in(mem_ready_in)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         ack_cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] model_rdata = '0;
  logic       model_err = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (reset_n_in && cpu_ack_out) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL unexpected_ack: got ack at cycle %0d, expected no ack", cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("ack_cycle", cyc, mon_e.ack_cyc);
        checkOutput("cpu_rdata", {24'd0, cpu_rdata_out}, {24'd0, mon_e.rdata});
        checkOutput("cpu_err", {31'd0, cpu_err_out}, {31'd0, mon_e.err});
      end
    end
  end

  // Called on a negedge; the DUT samples the request on the following rising edge.
  // dly = cycles after the strobe for a periph read, or the MEM_WAIT cycle carrying ready.
  task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic [7:0] wdata,
                               input int dly, input logic [7:0] sdata, input bit hold);
    int x, lat, when;
    bit periph, tout;
    periph = (addr[15:12] == 4'hF);
    cpu_addr_in = addr;
    cpu_we_in = we;
    cpu_wdata_in = wdata;
    cpu_req_in = 1'b1;
    periph_data_valid_in = 1'b0;
    mem_ready_in = 1'b0;
    x = cyc;
    if (periph && we) begin
      tout = 1'b0;
      lat = 2;
    end else if (periph) begin
      tout = (dly > TIMEOUT);
      lat = tout ? 2 + TIMEOUT : 2 + dly;
    end else begin
      tout = (dly > TIMEOUT);
      lat = tout ? 1 + TIMEOUT : 1 + dly;
    end
    if (tout) begin
      model_rdata = 8'hFF;
      model_err = 1'b1;
    end else begin
      model_err = 1'b0;
      if (!we) model_rdata = sdata;
    end
    sb.push_back('{rdata: model_rdata, err: model_err, ack_cyc: x + lat});

    @(negedge clk_in);
    if (periph) begin
      checkOutput("periph_strobe", {31'd0, periph_addr_valid_out}, 32'd1);
      checkOutput("periph_addr", {29'd0, periph_addr_out}, {29'd0, addr[2:0]});
      checkOutput("periph_we", {31'd0, periph_write_en_out}, {31'd0, we});
      checkOutput("periph_wdata", {24'd0, periph_wdata_out}, {24'd0, wdata});
      checkOutput("mem_req_idle", {31'd0, mem_req_out}, 32'd0);
      @(negedge clk_in);
      checkOutput("periph_strobe_drop", {31'd0, periph_addr_valid_out}, 32'd0);
    end else begin
      checkOutput("mem_req", {31'd0, mem_req_out}, 32'd1);
      checkOutput("mem_addr", {16'd0, mem_addr_out}, {16'd0, addr});
      checkOutput("mem_we", {31'd0, mem_we_out}, {31'd0, we});
      checkOutput("mem_wdata", {24'd0, mem_wdata_out}, {24'd0, wdata});
      checkOutput("periph_strobe_idle", {31'd0, periph_addr_valid_out}, 32'd0);
    end
    if (!tout && !(periph && we)) begin
      when = periph ? x + 1 + dly : x + dly;
      while (cyc < when) @(negedge clk_in);
      if (periph) begin
        periph_data_valid_in = 1'b1;
        periph_rdata_in = sdata;
      end else begin
        mem_ready_in = 1'b1;
        mem_rdata_in = sdata;
      end
      @(negedge clk_in);
      periph_data_valid_in = 1'b0;
      mem_ready_in = 1'b0;
    end
    while (cyc < x + lat) @(negedge clk_in);
    if (!periph) checkOutput("mem_req_dropped", {31'd0, mem_req_out}, 32'd0);
    if (!hold) cpu_req_in = 1'b0;
  endtask

  // Idle cycles after an ack, optionally with slave pulses that must be ignored.
  task automatic idleGap(input int n, input bit stray);
    @(negedge clk_in);
    if (stray) begin
      periph_data_valid_in = 1'b1;
      periph_rdata_in = 8'($urandom);
      mem_ready_in = 1'b1;
      mem_rdata_in = 8'($urandom);
    end
    @(negedge clk_in);
    periph_data_valid_in = 1'b0;
    mem_ready_in = 1'b0;
    checkOutput("idle_rdata_hold", {24'd0, cpu_rdata_out}, {24'd0, model_rdata});
    repeat (n) @(negedge clk_in);
  endtask

  task automatic printSummary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  initial begin
    #1000000;
    n_checks++;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    printSummary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] a;
    logic        w;
    int          d;
    bit          h;

    repeat (3) @(negedge clk_in);
    checkOutput("rst_ack", {31'd0, cpu_ack_out}, 32'd0);
    checkOutput("rst_rdata", {24'd0, cpu_rdata_out}, 32'd0);
    checkOutput("rst_err", {31'd0, cpu_err_out}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req_out}, 32'd0);
    checkOutput("rst_periph_strobe", {31'd0, periph_addr_valid_out}, 32'd0);
    reset_n_in = 1'b1;
    @(negedge clk_in);

    applyStimulus(16'hF001, 1'b1, 8'hA5, 0, 8'h00, 1'b0);
    idleGap(1, 1'b0);
    applyStimulus(16'hF006, 1'b0, 8'h00, 1, 8'h01, 1'b0);
    idleGap(1, 1'b1);
    applyStimulus(16'h1234, 1'b0, 8'h00, 4, 8'h5A, 1'b0);
    idleGap(0, 1'b0);
    applyStimulus(16'h2000, 1'b0, 8'h00, 99, 8'h00, 1'b0);
    idleGap(0, 1'b0);
    applyStimulus(16'h3000, 1'b1, 8'h77, 2, 8'h00, 1'b0);
    idleGap(0, 1'b0);
    applyStimulus(16'h0ABC, 1'b0, 8'h00, TIMEOUT, 8'h3C, 1'b0);
    idleGap(0, 1'b0);

    // Abort a memory access with reset while it waits for ready.
    cpu_addr_in = 16'h4000;
    cpu_we_in = 1'b0;
    cpu_req_in = 1'b1;
    repeat (4) @(negedge clk_in);
    checkOutput("mem_req_before_reset", {31'd0, mem_req_out}, 32'd1);
    reset_n_in = 1'b0;
    #1;
    checkOutput("reset_mem_req", {31'd0, mem_req_out}, 32'd0);
    checkOutput("reset_ack", {31'd0, cpu_ack_out}, 32'd0);
    cpu_req_in = 1'b0;
    model_rdata = '0;
    model_err = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_n_in = 1'b1;
    checkOutput("post_reset_rdata", {24'd0, cpu_rdata_out}, 32'd0);
    @(negedge clk_in);
    applyStimulus(16'hF003, 1'b0, 8'h00, 2, 8'hC3, 1'b0);
    idleGap(0, 1'b0);

    applyStimulus(16'hF005, 1'b0, 8'h00, 1, 8'h9E, 1'b1);
    @(negedge clk_in);
    applyStimulus(16'h0100, 1'b0, 8'h00, 3, 8'h42, 1'b0);
    idleGap(0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      if ($urandom_range(0, 1) == 1) a = {4'hF, 12'($urandom)};
      else a = 16'($urandom_range(0, 16'hEFFF));
      if (w && a[15:12] != 4'hF) d = $urandom_range(1, TIMEOUT);
      else d = $urandom_range(1, TIMEOUT + 3);
      h = ($urandom_range(0, 3) == 0);
      applyStimulus(a, w, 8'($urandom), d, 8'($urandom), h);
      if (h) @(negedge clk_in);
      else idleGap($urandom_range(0, 2), 1'($urandom));
    end

    repeat (5) @(negedge clk_in);
    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    printSummary();
    $finish;
  end

endmodule
